// File: rtl/player_phys_pkg.sv
// Shared state encoding, gravity constants and platform-line geometry
// for the player vertical-motion block.
package player_phys_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_FALL   = 2'd1,
    ST_OUT    = 2'd2
  } phys_state_e;

  localparam logic GRAV_DOWN = 1'b0;
  localparam logic GRAV_UP   = 1'b1;

  function automatic int line_y(input int k, input int base, input int spacing);
    return base + k * spacing;
  endfunction

endpackage

// File: rtl/player_physics_surface_detect.sv
// Combinational landing/bounds resolver: given the current height, the step
// speed and gravity, returns whether a line catches the player and the next y.
module surface_detect
  import player_phys_pkg::*;
#(
  parameter int Y_W          = 9,
  parameter int NUM_LINES    = 3,
  parameter int LINE_BASE    = 120,
  parameter int LINE_SPACING = 120,
  parameter int PLAYER_H     = 60,
  parameter int SCREEN_H     = 480,
  parameter int VEL_W        = 3
) (
  input  logic [Y_W-1:0]       height,
  input  logic [VEL_W-1:0]     vel_nxt,
  input  logic                 grav_dir,
  input  logic [NUM_LINES-1:0] lines,
  output logic                 hit,
  output logic [Y_W-1:0]       clamp_y,
  output logic                 out_of_bounds
);

  localparam int CW = Y_W + 1;
  localparam logic [CW-1:0] PH      = CW'(PLAYER_H);
  localparam logic [CW-1:0] FLOOR_Y = CW'(SCREEN_H - PLAYER_H);

  function automatic logic [CW-1:0] surf_y(input int k);
    return CW'(line_y(k, LINE_BASE, LINE_SPACING));
  endfunction

  logic [CW-1:0] h_ext;
  logic [CW-1:0] v_ext;
  logic [CW-1:0] y_cand;
  logic [CW-1:0] surf;
  logic          underflow;

  always_comb begin
    h_ext     = {1'b0, height};
    v_ext     = CW'(vel_nxt);
    underflow = (grav_dir == GRAV_UP) && (v_ext > h_ext);
    y_cand    = (grav_dir == GRAV_UP) ? h_ext - v_ext : h_ext + v_ext;
    hit       = 1'b0;
    surf      = '0;
    // Scan order makes the nearest line in the direction of travel win.
    if (grav_dir == GRAV_DOWN) begin
      for (int k = NUM_LINES - 1; k >= 0; k--) begin
        if (lines[k] && (surf_y(k) >= h_ext + PH) && (surf_y(k) <= y_cand + PH)) begin
          hit  = 1'b1;
          surf = surf_y(k);
        end
      end
    end else begin
      for (int k = 0; k < NUM_LINES; k++) begin
        if (lines[k] && (underflow || (y_cand <= surf_y(k))) && (surf_y(k) <= h_ext)) begin
          hit  = 1'b1;
          surf = surf_y(k);
        end
      end
    end

    out_of_bounds = !hit && ((grav_dir == GRAV_DOWN) ? (y_cand > FLOOR_Y) : underflow);

    if (hit) begin
      clamp_y = (grav_dir == GRAV_DOWN) ? Y_W'(surf - PH) : Y_W'(surf);
    end else if (out_of_bounds) begin
      clamp_y = (grav_dir == GRAV_DOWN) ? Y_W'(FLOOR_Y) : '0;
    end else begin
      clamp_y = Y_W'(y_cand);
    end
  end

endmodule

// File: rtl/player_physics.sv
// Player vertical motion: gravity-flip handshake, capped acceleration, line landing.
// Define PLAYER_DOUBLE_FLIP_EN to allow one airborne flip per airtime.
module player_physics
  import player_phys_pkg::*;
#(
  parameter int Y_W          = 9,
  parameter int NUM_LINES    = 3,
  parameter int LINE_BASE    = 120,
  parameter int LINE_SPACING = 120,
  parameter int PLAYER_H     = 60,
  parameter int SCREEN_H     = 480,
  parameter int START_Y      = 180,
  parameter int MAX_VEL      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           is_dead,
  input  logic [NUM_LINES-1:0]           lines,
  input  logic                           flip_req,
  output logic [Y_W-1:0]                 height,
  output logic                           grav_dir,
  output logic                           grounded,
  output logic [$clog2(MAX_VEL+1)-1:0]   vel,
  output logic                           flip_ack,
  output logic                           fell_out
);

  localparam int VEL_W = $clog2(MAX_VEL + 1);

  phys_state_e      state;
  logic [VEL_W-1:0] vel_nxt;
  logic [VEL_W-1:0] vel_probe;
  logic             hit;
  logic             out_of_bounds;
  logic [Y_W-1:0]   clamp_y;
`ifdef PLAYER_DOUBLE_FLIP_EN
  logic             air_flip_avail;
`endif

  assign vel_nxt   = (vel >= VEL_W'(MAX_VEL)) ? VEL_W'(MAX_VEL) : vel + 1'b1;
  // A zero step turns the landing test into the "still supported" test while grounded.
  assign vel_probe = (state == ST_GROUND) ? '0 : vel_nxt;
  assign grounded  = (state == ST_GROUND);

  surface_detect #(
    .Y_W          (Y_W),
    .NUM_LINES    (NUM_LINES),
    .LINE_BASE    (LINE_BASE),
    .LINE_SPACING (LINE_SPACING),
    .PLAYER_H     (PLAYER_H),
    .SCREEN_H     (SCREEN_H),
    .VEL_W        (VEL_W)
  ) u_surface (
    .height        (height),
    .vel_nxt       (vel_probe),
    .grav_dir      (grav_dir),
    .lines         (lines),
    .hit           (hit),
    .clamp_y       (clamp_y),
    .out_of_bounds (out_of_bounds)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      height   <= Y_W'(START_Y);
      grav_dir <= GRAV_DOWN;
      vel      <= '0;
      state    <= ST_FALL;
      flip_ack <= 1'b0;
      fell_out <= 1'b0;
`ifdef PLAYER_DOUBLE_FLIP_EN
      air_flip_avail <= 1'b1;
`endif
    end else begin
      flip_ack <= 1'b0;
      if (tick && !is_dead) begin
        case (state)
          ST_GROUND: begin
            if (flip_req) begin
              grav_dir <= ~grav_dir;
              vel      <= '0;
              state    <= ST_FALL;
              flip_ack <= 1'b1;
            end else if (!hit) begin
              vel   <= '0;
              state <= ST_FALL;
            end
          end
          ST_FALL: begin
`ifdef PLAYER_DOUBLE_FLIP_EN
            if (flip_req && air_flip_avail) begin
              grav_dir       <= ~grav_dir;
              vel            <= '0;
              flip_ack       <= 1'b1;
              air_flip_avail <= 1'b0;
            end else
`endif
            if (hit) begin
              height <= clamp_y;
              vel    <= '0;
              state  <= ST_GROUND;
`ifdef PLAYER_DOUBLE_FLIP_EN
              air_flip_avail <= 1'b1;
`endif
            end else if (out_of_bounds) begin
              height   <= clamp_y;
              fell_out <= 1'b1;
              state    <= ST_OUT;
            end else begin
              height <= clamp_y;
              vel    <= vel_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
